// File: rtl/disp_pkg.sv
// Shared definitions for the calculator display path: display-select codes,
// scan FSM encoding, anode constants and small decode helpers.
package disp_pkg;

    // Select codes understood by the disp mux
    localparam logic [1:0] DS_SAVE1 = 2'b00;
    localparam logic [1:0] DS_OP    = 2'b01;
    localparam logic [1:0] DS_SAVE2 = 2'b10;
    localparam logic [1:0] DS_NONE  = 2'b11;

    // All digits dark (anodes are active-low)
    localparam logic [2:0] ANODE_OFF = 3'b111;

    // Scan sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BLANK = 2'b01,
        ST_SHOW  = 2'b10
    } scan_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Scan order save_1 -> Op -> save_2 -> save_1; the unused code folds back to save_1
    function automatic logic [1:0] next_digit(input logic [1:0] d);
        logic [1:0] n;
        case (d)
            DS_SAVE1: n = DS_OP;
            DS_OP:    n = DS_SAVE2;
            default:  n = DS_SAVE1;
        endcase
        return n;
    endfunction

    // Active-low one-hot anode for a select code; never lights anything for DS_NONE
    function automatic logic [2:0] anode_for(input logic [1:0] d);
        logic [2:0] a;
        case (d)
            DS_SAVE1: a = 3'b110;
            DS_OP:    a = 3'b101;
            DS_SAVE2: a = 3'b011;
            default:  a = ANODE_OFF;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/disp_scan_ctrl_if.sv
// Bundle between the display scan sequencer and its surroundings:
// enable and blink request in, mux select, anodes and digit strobe out.
interface disp_scan_ctrl_if;
    logic       en;
    logic [1:0] blink_field;
    logic [1:0] display_state;
    logic [2:0] anode;
    logic       digit_tick;

    // Sequencer side
    modport master (
        input  en,
        input  blink_field,
        output display_state,
        output anode,
        output digit_tick
    );

    // Consumer side (board logic / disp mux)
    modport slave (
        output en,
        output blink_field,
        input  display_state,
        input  anode,
        input  digit_tick
    );
endinterface

// File: rtl/disp_tick_gen.sv
// Phase-length counter for the scan sequencer: synchronous clear,
// increment, and a terminal-count flag against a run-time terminal value.
module disp_tick_gen #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] term,
    output logic         tc
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Clear has priority so the FSM can restart a phase on the same cycle it ends one
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == term);

endmodule

// File: rtl/disp_scan_ctrl.sv
// Display scan sequencer: steps the disp select through save_1 -> Op -> save_2,
// lights the matching active-low anode for CLK_DIV cycles, and darkens all
// anodes for BLANK_CYC cycles before each digit to suppress ghosting.
// Optional feature macro: DISP_BLINK_EN (blink one selected field every
// BLINK_DIV frames).
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 2,
    parameter int BLINK_DIV = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    disp_scan_ctrl_if.master        bus
);

    localparam int             CW         = $clog2(max_int(CLK_DIV, BLANK_CYC) + 1);
    localparam logic [CW-1:0]  SHOW_TERM  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]  BLANK_TERM = CW'((BLANK_CYC > 0) ? (BLANK_CYC - 1) : 0);
    localparam logic           NO_GAP     = (BLANK_CYC == 0);

    scan_state_e state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic [2:0]  anode_q, anode_d;
    logic        tick_q, tick_d;

    logic          cnt_clr;
    logic          cnt_inc;
    logic [CW-1:0] cnt_term;
    logic          cnt_tc;
    logic          wrap;
    logic          hide_d;

    disp_tick_gen #(
        .W (CW)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .term  (cnt_term),
        .tc    (cnt_tc)
    );

    // Next-state, counter control and select advance; en low always wins
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        tick_d   = 1'b0;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        wrap     = 1'b0;
        cnt_term = (state_q == ST_BLANK) ? BLANK_TERM : SHOW_TERM;
        case (state_q)
            ST_IDLE: begin
                cnt_clr = 1'b1;
                if (bus.en) begin
                    state_d = NO_GAP ? ST_SHOW : ST_BLANK;
                end
            end
            ST_BLANK: begin
                if (!bus.en) begin
                    state_d = ST_IDLE;
                    cnt_clr = 1'b1;
                end else if (cnt_tc) begin
                    state_d = ST_SHOW;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_SHOW: begin
                if (!bus.en) begin
                    state_d = ST_IDLE;
                    cnt_clr = 1'b1;
                end else if (cnt_tc) begin
                    sel_d   = next_digit(sel_q);
                    tick_d  = 1'b1;
                    wrap    = (sel_q == DS_SAVE2);
                    state_d = NO_GAP ? ST_SHOW : ST_BLANK;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_clr = 1'b1;
            end
        endcase
    end

`ifdef DISP_BLINK_EN
    localparam int            FW         = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_DIV - 1);

    logic [FW-1:0] frame_q, frame_d;
    logic          blink_phase_q, blink_phase_d;

    // Count completed frames; flip the blink phase every BLINK_DIV of them
    always_comb begin
        frame_d       = frame_q;
        blink_phase_d = blink_phase_q;
        if (wrap) begin
            if (frame_q == FRAME_LAST) begin
                frame_d       = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_d = frame_q + 1'b1;
            end
        end
        hide_d = blink_phase_d && (bus.blink_field != DS_NONE) && (bus.blink_field == sel_d);
    end

    // Frame counter and blink phase registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q       <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            frame_q       <= frame_d;
            blink_phase_q <= blink_phase_d;
        end
    end
`else
    // Without blinking the field request is accepted but has no effect
    logic unused_blink;
    localparam int unused_blink_div = BLINK_DIV;
    assign unused_blink = ^bus.blink_field ^ wrap;

    // No digit is ever suppressed
    always_comb begin
        hide_d = 1'b0;
    end
`endif

    // Anodes follow the upcoming state so they line up with the registered select
    always_comb begin
        anode_d = ANODE_OFF;
        if ((state_d == ST_SHOW) && !hide_d) begin
            anode_d = anode_for(sel_d);
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= DS_SAVE1;
            anode_q <= ANODE_OFF;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            anode_q <= anode_d;
            tick_q  <= tick_d;
        end
    end

    assign bus.display_state = sel_q;
    assign bus.anode         = anode_q;
    assign bus.digit_tick    = tick_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl: one instance with a blanking gap, one without,
// both shadowed by a schedule-based reference model.
module tb_disp_scan_ctrl;

    localparam int CLK_DIV   = 4;
    localparam int BLINK_DIV = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en_drv = 1'b0;
    logic [1:0] bf_drv = 2'b11;

    int n_chk  = 0;
    int n_fail = 0;
    int t_now  = -1;
    bit chk_on = 1'b0;

    disp_scan_ctrl_if ifc_a ();
    disp_scan_ctrl_if ifc_b ();

    assign ifc_a.en          = en_drv;
    assign ifc_a.blink_field = bf_drv;
    assign ifc_b.en          = en_drv;
    assign ifc_b.blink_field = bf_drv;

    disp_scan_ctrl #(.CLK_DIV(CLK_DIV), .BLANK_CYC(1), .BLINK_DIV(BLINK_DIV)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc_a)
    );

    disp_scan_ctrl #(.CLK_DIV(CLK_DIV), .BLANK_CYC(0), .BLINK_DIV(BLINK_DIV)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc_b)
    );

    always #5 clk = ~clk;

    // Reference model: each instance runs a periodic schedule of BLANK_CYC dark
    // cycles followed by CLK_DIV lit cycles per digit.
    int blank_c [2] = '{1, 0};
    int m_run   [2];
    int m_digit [2];
    int m_pos   [2];
    int m_wraps [2];
    int m_tick  [2];
    int m_bf    [2];

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_run[k] = 0; m_digit[k] = 0; m_pos[k] = 0;
                m_wraps[k] = 0; m_tick[k] = 0; m_bf[k] = 3;
            end else begin
                m_tick[k] = 0;
                m_bf[k]   = int'(bf_drv);
                if (!en_drv) begin
                    m_run[k] = 0;
                end else if (m_run[k] == 0) begin
                    m_run[k] = 1;
                    m_pos[k] = 0;
                end else begin
                    m_pos[k]++;
                    if (m_pos[k] == CLK_DIV + blank_c[k]) begin
                        m_pos[k]   = 0;
                        m_digit[k] = (m_digit[k] + 1) % 3;
                        m_tick[k]  = 1;
                        if (m_digit[k] == 0) m_wraps[k]++;
                    end
                end
            end
        end
    end

    function automatic int exp_anode(input int k);
        logic [2:0] a;
        bit hide;
        a = 3'b111;
`ifdef DISP_BLINK_EN
        hide = ((m_wraps[k] / BLINK_DIV) % 2 == 1) && (m_bf[k] == m_digit[k]);
`else
        hide = 1'b0;
`endif
        if (m_run[k] == 1 && m_pos[k] >= blank_c[k] && !hide) a[m_digit[k]] = 1'b0;
        return int'(a);
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0d, time %0t)", nm, act, exp, t_now, $time);
        end
    endtask

    // Cycle-by-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (chk_on) begin
            check("model_anode_a", int'(ifc_a.anode), exp_anode(0));
            check("model_sel_a",   int'(ifc_a.display_state), m_digit[0]);
            check("model_tick_a",  int'(ifc_a.digit_tick), m_tick[0]);
            check("model_anode_b", int'(ifc_b.anode), exp_anode(1));
            check("model_sel_b",   int'(ifc_b.display_state), m_digit[1]);
            check("model_tick_b",  int'(ifc_b.digit_tick), m_tick[1]);
        end
    end

    // Advance to the sampling point (negedge) of cycle t after the enable edge
    task automatic goto(input int t);
        while (t_now < t) begin
            @(posedge clk);
            t_now++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [1:0] bf);
        rst_n  = 1'b0;
        en_drv = 1'b1;
        bf_drv = bf;
        repeat (3) begin
            @(negedge clk);
            check("rst_anode_a", int'(ifc_a.anode), 7);
            check("rst_sel_a",   int'(ifc_a.display_state), 0);
            check("rst_tick_a",  int'(ifc_a.digit_tick), 0);
            check("rst_anode_b", int'(ifc_b.anode), 7);
        end
        #2 rst_n = 1'b1;
        t_now = -1;
    endtask

    int exp_an_a  [16] = '{7,6,6,6,6,7,5,5,5,5,7,3,3,3,3,7};
    int exp_sel_a [16] = '{0,0,0,0,0,1,1,1,1,1,2,2,2,2,2,0};
    int exp_tk_a  [16] = '{0,0,0,0,0,1,0,0,0,0,1,0,0,0,0,1};
    int exp_an_b  [16] = '{6,6,6,6,5,5,5,5,3,3,3,3,6,6,6,6};
    int exp_sel_b [16] = '{0,0,0,0,1,1,1,1,2,2,2,2,0,0,0,0};
    int exp_tk_b  [16] = '{0,0,0,0,1,0,0,0,1,0,0,0,1,0,0,0};

    initial begin
        int blink_dark;
`ifdef DISP_BLINK_EN
        blink_dark = 7;
`else
        blink_dark = 5;
`endif
        #1 rst_n = 1'b0;
        chk_on = 1'b1;

        // Reset values, then the first frame of both instances
        do_reset(2'b01);
        for (int t = 0; t < 16; t++) begin
            goto(t);
            check("frame_anode_a", int'(ifc_a.anode), exp_an_a[t]);
            check("frame_sel_a",   int'(ifc_a.display_state), exp_sel_a[t]);
            check("frame_tick_a",  int'(ifc_a.digit_tick), exp_tk_a[t]);
            check("nogap_anode_b", int'(ifc_b.anode), exp_an_b[t]);
            check("nogap_sel_b",   int'(ifc_b.display_state), exp_sel_b[t]);
            check("nogap_tick_b",  int'(ifc_b.digit_tick), exp_tk_b[t]);
        end

        // en drops on the advance cycle of digit Op in the second frame
        goto(24);
        check("pre_drop_anode", int'(ifc_a.anode), 5);
        en_drv = 1'b0;
        goto(25);
        check("drop_anode", int'(ifc_a.anode), 7);
        check("drop_sel",   int'(ifc_a.display_state), 1);
        check("drop_tick",  int'(ifc_a.digit_tick), 0);
        en_drv = 1'b1;
        goto(26);
        check("resume_blank", int'(ifc_a.anode), 7);
        check("resume_sel",   int'(ifc_a.display_state), 1);
        for (int t = 27; t <= 30; t++) begin
            goto(t);
            check("resume_show", int'(ifc_a.anode), 5);
        end
        goto(31);
        check("resume_tick", int'(ifc_a.digit_tick), 1);
        check("resume_next", int'(ifc_a.display_state), 2);

        // Asynchronous reset during SHOW of save_2
        goto(33);
        check("pre_rst_anode", int'(ifc_a.anode), 3);
        #1 rst_n = 1'b0;
        #1;
        check("async_anode", int'(ifc_a.anode), 7);
        check("async_sel",   int'(ifc_a.display_state), 0);
        check("async_tick",  int'(ifc_a.digit_tick), 0);

        // Blink on Op: lit in frames 0-1, dark in frames 2-3 when enabled
        do_reset(2'b01);
        for (int f = 0; f < 4; f++) begin
            goto(15 * f + 7);
            check("blink_op", int'(ifc_a.anode), (f >= 2) ? blink_dark : 5);
        end
        goto(67);
        check("blink_op_f4", int'(ifc_a.anode), 5);
        bf_drv = 2'b11;
        goto(97);
        check("blink_none_f6", int'(ifc_a.anode), 5);

        // Randomised enable, blink field and reset activity
        for (int i = 0; i < 3000; i++) begin
            int r;
            @(negedge clk);
            r = $urandom_range(0, 99);
            if (r < 3) en_drv = ~en_drv;
            else if (!en_drv && r < 25) en_drv = 1'b1;
            else if (r < 28) bf_drv = 2'($urandom_range(0, 3));
            else if (r == 28) begin
                #1 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end

        @(negedge clk);
        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
